// File: rtl/eth_frame_scheduler.sv
// Round-robin scheduler sharing one single-beat Ethernet framer among NUM_SRC payload sources.
// One beat per frame; the next grant waits for framer tlast (or timeout) plus MIN_GAP idle cycles.

module eth_frame_scheduler_lane #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  sel_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [15:0]           sync_i,
    input  logic [15:0]           ltype_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [15:0]           sync_o,
    output logic [15:0]           ltype_o
);
    // Unselected lanes drive zero so the top can OR-merge them into a one-hot mux.
    assign data_o  = sel_i ? data_i  : '0;
    assign sync_o  = sel_i ? sync_i  : '0;
    assign ltype_o = sel_i ? ltype_i : '0;
endmodule

module eth_frame_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MIN_GAP    = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    S_AXIS_tdata,
    input  logic [NUM_SRC-1:0]               S_AXIS_tvalid,
    output logic [NUM_SRC-1:0]               S_AXIS_tready,
    input  logic [NUM_SRC*16-1:0]            Src_SyncWord,
    input  logic [NUM_SRC*16-1:0]            Src_Link_Type,
    output logic [DATA_WIDTH-1:0]            M_AXIS_tdata,
    output logic                             M_AXIS_tvalid,
    input  logic                             M_AXIS_tready,
    output logic [15:0]                      Cur_SyncWord,
    output logic [15:0]                      Cur_Link_Type,
    input  logic                             Mon_tvalid,
    input  logic                             Mon_tready,
    input  logic                             Mon_tlast,
    output logic [$clog2(NUM_SRC)-1:0]       Grant_Id,
    output logic                             Busy,
    output logic                             Timeout_Err,
    output logic [31:0]                      Frame_Count
);
    localparam int IDW = $clog2(NUM_SRC);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [15:0]           sync;
        logic [15:0]           ltype;
        logic [IDW-1:0]        id;
    } frame_ctx_t;

    state_e                            state_q, state_d;
    frame_ctx_t                        ctx_q, ctx_d;
    logic                              mvalid_q, mvalid_d;
    logic [IDW-1:0]                    rr_last_q, rr_last_d;
    logic [TW-1:0]                     to_cnt_q, to_cnt_d;
    logic [GW-1:0]                     gap_cnt_q, gap_cnt_d;
    logic                              to_err_q, to_err_d;
    logic [31:0]                       fcnt_q, fcnt_d;

    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data, lane_data;
    logic [NUM_SRC-1:0][15:0]           src_sync, src_ltype, lane_sync, lane_ltype;
    logic [DATA_WIDTH-1:0]              sel_data;
    logic [15:0]                        sel_sync, sel_ltype;
    logic [IDW-1:0]                     cand, win_id;
    logic                               win_found, accept, mon_last, frame_end;
    logic [NUM_SRC-1:0]                 grant_oh;

    assign src_data  = S_AXIS_tdata;
    assign src_sync  = Src_SyncWord;
    assign src_ltype = Src_Link_Type;

    // Search starts just past the last winner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDW'((int'(rr_last_q) + k) % NUM_SRC);
            if (!win_found && S_AXIS_tvalid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign accept = ARESETN && (state_q == IDLE) && win_found;

    always_comb begin
        grant_oh = '0;
        if (accept) grant_oh[win_id] = 1'b1;
    end

    assign S_AXIS_tready = grant_oh;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        eth_frame_scheduler_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .sel_i   (grant_oh[g]),
            .data_i  (src_data[g]),
            .sync_i  (src_sync[g]),
            .ltype_i (src_ltype[g]),
            .data_o  (lane_data[g]),
            .sync_o  (lane_sync[g]),
            .ltype_o (lane_ltype[g])
        );
    end

    always_comb begin
        sel_data  = '0;
        sel_sync  = '0;
        sel_ltype = '0;
        for (int g = 0; g < NUM_SRC; g++) begin
            sel_data  = sel_data  | lane_data[g];
            sel_sync  = sel_sync  | lane_sync[g];
            sel_ltype = sel_ltype | lane_ltype[g];
        end
    end

    assign mon_last = Mon_tvalid && Mon_tready && Mon_tlast;

    always_comb begin
        state_d   = state_q;
        ctx_d     = ctx_q;
        mvalid_d  = mvalid_q;
        rr_last_d = rr_last_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        to_err_d  = to_err_q;
        fcnt_d    = fcnt_q;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctx_d     = '{data: sel_data, sync: sel_sync, ltype: sel_ltype, id: win_id};
                    rr_last_d = win_id;
                    mvalid_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (M_AXIS_tready) begin
                    mvalid_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Completion has priority over a coincident timeout.
                if (mon_last) begin
                    fcnt_d    = fcnt_q + 32'd1;
                    frame_end = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    to_err_d  = 1'b1;
                    frame_end = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (frame_end) begin
            state_d   = (MIN_GAP == 0) ? IDLE : GAP;
            gap_cnt_d = GAP_LAST;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            ctx_q     <= '0;
            mvalid_q  <= 1'b0;
            rr_last_q <= IDW'(NUM_SRC - 1);
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            to_err_q  <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            ctx_q     <= ctx_d;
            mvalid_q  <= mvalid_d;
            rr_last_q <= rr_last_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            to_err_q  <= to_err_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign M_AXIS_tdata  = ctx_q.data;
    assign M_AXIS_tvalid = mvalid_q;
    assign Cur_SyncWord  = ctx_q.sync;
    assign Cur_Link_Type = ctx_q.ltype;
    assign Grant_Id      = ctx_q.id;
    assign Busy          = (state_q != IDLE);
    assign Timeout_Err   = to_err_q;
    assign Frame_Count   = fcnt_q;

endmodule

// File: tb/tb_eth_frame_scheduler.sv
// Bench for eth_frame_scheduler: vector table, directed corner sequences and randomized frames
// checked against a transaction-level round-robin / frame-count model.

module tb_eth_frame_scheduler;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MG = 2;
    localparam int TO = 16;

    logic                   ACLK = 1'b0;
    logic                   ARESETN = 1'b0;
    logic [N-1:0][DW-1:0]   sd;
    logic [N-1:0][15:0]     sw, lt;
    logic [N-1:0]           svld, srdy;
    logic [DW-1:0]          mdata;
    logic                   mvld, mrdy;
    logic [15:0]            csw, clt;
    logic                   mon_v, mon_r, mon_l;
    logic [1:0]             gid;
    logic                   busy, terr;
    logic [31:0]            fcnt;

    eth_frame_scheduler #(.NUM_SRC(N), .DATA_WIDTH(DW), .MIN_GAP(MG), .TIMEOUT(TO)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXIS_tdata  (sd),
        .S_AXIS_tvalid (svld),
        .S_AXIS_tready (srdy),
        .Src_SyncWord  (sw),
        .Src_Link_Type (lt),
        .M_AXIS_tdata  (mdata),
        .M_AXIS_tvalid (mvld),
        .M_AXIS_tready (mrdy),
        .Cur_SyncWord  (csw),
        .Cur_Link_Type (clt),
        .Mon_tvalid    (mon_v),
        .Mon_tready    (mon_r),
        .Mon_tlast     (mon_l),
        .Grant_Id      (gid),
        .Busy          (busy),
        .Timeout_Err   (terr),
        .Frame_Count   (fcnt)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_pass = 0;
    int exp_fc = 0;
    bit exp_terr = 1'b0;
    int rr_m = N - 1;

    typedef struct {
        logic [N-1:0] vld;
        int           rdly;
        int           tdly;
        int           exp_src;
    } vec_t;
    vec_t tbl[12];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic scramble_src();
        for (int i = 0; i < N; i++) begin
            sd[i] = {$urandom, $urandom};
            sw[i] = 16'($urandom);
            lt[i] = 16'($urandom);
        end
    endtask

    // mode 0: framer tlast after tdly cycles; 1: no tlast (timeout); 2: stop inside WAIT_DONE
    task automatic do_frame(input logic [N-1:0] v, input int exp_src, input int rdly,
                            input int tdly, input int mode, input string tag);
        logic [DW-1:0] ed;
        logic [15:0]   esw, elt;
        int            cnt;
        svld = v;
        #1;
        cnt = 0;
        while (srdy == '0 && cnt < 40) begin
            tick();
            cnt++;
        end
        if (srdy == '0) begin
            n_chk++;
            $display("FAIL %s grant: no tready within %0d cycles, wanted source %0d", tag, cnt, exp_src);
            svld = '0;
            return;
        end
        chk({tag, " tready"}, 64'(srdy), 64'(N'(1) << exp_src));
        ed  = sd[exp_src];
        esw = sw[exp_src];
        elt = lt[exp_src];
        mrdy = 1'b0;
        tick();
        svld = '0;
        scramble_src();
        rr_m = exp_src;
        chk({tag, " mvalid"}, 64'(mvld), 64'd1);
        chk({tag, " mdata"}, mdata, ed);
        chk({tag, " sync"}, 64'(csw), 64'(esw));
        chk({tag, " ltype"}, 64'(clt), 64'(elt));
        chk({tag, " grant_id"}, 64'(gid), 64'(exp_src));
        for (int i = 0; i < rdly; i++) begin
            svld = '1;
            tick();
            chk({tag, " hold mvalid"}, 64'(mvld), 64'd1);
            chk({tag, " hold mdata"}, mdata, ed);
            chk({tag, " no tready in SEND"}, 64'(srdy), 64'd0);
        end
        svld = '0;
        mrdy = 1'b1;
        tick();
        mrdy = 1'b0;
        chk({tag, " mvalid drop"}, 64'(mvld), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        if (mode == 2) begin
            repeat (tdly) tick();
            return;
        end
        if (mode == 0) begin
            for (int i = 0; i < tdly; i++) begin
                mon_v = 1'($urandom_range(0, 1));
                mon_r = 1'($urandom_range(0, 1));
                mon_l = (mon_v && mon_r) ? 1'b0 : 1'($urandom_range(0, 1));
                tick();
            end
            mon_v = 1'b1; mon_r = 1'b1; mon_l = 1'b1;
            tick();
            mon_v = 1'b0; mon_r = 1'b0; mon_l = 1'b0;
            exp_fc++;
        end else begin
            cnt = 0;
            while (!terr && cnt < TO + 8) begin
                tick();
                cnt++;
            end
            chk({tag, " timeout latency"}, 64'(cnt), 64'(TO));
            exp_terr = 1'b1;
        end
        chk({tag, " frame_count"}, 64'(fcnt), 64'(exp_fc));
        chk({tag, " timeout_err"}, 64'(terr), 64'(exp_terr));
        svld = '1;
        #1;
        cnt = 0;
        while (busy && cnt < MG + 8) begin
            chk({tag, " no tready in GAP"}, 64'(srdy), 64'd0);
            tick();
            cnt++;
        end
        svld = '0;
        chk({tag, " gap length"}, 64'(cnt), 64'(MG));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " tready"}, 64'(srdy), 64'd0);
        chk({tag, " mvalid"}, 64'(mvld), 64'd0);
        chk({tag, " mdata"}, mdata, 64'd0);
        chk({tag, " sync"}, 64'(csw), 64'd0);
        chk({tag, " ltype"}, 64'(clt), 64'd0);
        chk({tag, " grant_id"}, 64'(gid), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " timeout_err"}, 64'(terr), 64'd0);
        chk({tag, " frame_count"}, 64'(fcnt), 64'd0);
    endtask

    initial begin
        logic [N-1:0] v;
        int           e;
        // Grant sequence worked out by hand from round-robin rules, starting from reset.
        tbl[0]  = '{4'b1111, 0, 2, 0};
        tbl[1]  = '{4'b1111, 1, 0, 1};
        tbl[2]  = '{4'b1111, 0, 5, 2};
        tbl[3]  = '{4'b1111, 2, 1, 3};
        tbl[4]  = '{4'b1111, 0, 3, 0};
        tbl[5]  = '{4'b1111, 0, 0, 1};
        tbl[6]  = '{4'b0100, 1, 4, 2};
        tbl[7]  = '{4'b1001, 0, 2, 3};
        tbl[8]  = '{4'b0110, 0, 1, 1};
        tbl[9]  = '{4'b1000, 3, 6, 3};
        tbl[10] = '{4'b0001, 0, 0, 0};
        tbl[11] = '{4'b1010, 1, 2, 1};

        svld = '0; mrdy = 1'b0; mon_v = 1'b0; mon_r = 1'b0; mon_l = 1'b0;
        scramble_src();
        ARESETN = 1'b0;
        repeat (3) tick();
        svld = '1;
        #1;
        check_reset_state("reset");
        svld = '0;
        ARESETN = 1'b1;
        tick();

        for (int i = 0; i < 12; i++)
            do_frame(tbl[i].vld, tbl[i].exp_src, tbl[i].rdly, tbl[i].tdly, 0, $sformatf("vec%0d", i));

        sd[2] = 64'hDEAD_BEEF;
        do_frame(4'b0100, 2, 0, 8, 0, "single src2");
        do_frame(4'b0010, 1, 5, 3, 0, "stall src1");
        do_frame(4'b0001, 0, 0, TO - 1, 0, "tlast at timeout edge");

        for (int i = 0; i < 40; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            e = rr_pick(rr_m, v);
            do_frame(v, e, $urandom_range(0, 3), $urandom_range(0, TO - 1), 0, $sformatf("rnd%0d", i));
        end

        e = rr_pick(rr_m, 4'b0100);
        do_frame(4'b0100, e, 0, 0, 1, "timeout");
        e = rr_pick(rr_m, 4'b1111);
        do_frame(4'b1111, e, 0, 2, 0, "after timeout");

        e = rr_pick(rr_m, 4'b0110);
        do_frame(4'b0110, e, 0, 3, 2, "abort");
        ARESETN = 1'b0;
        svld = '1;
        tick();
        check_reset_state("mid reset");
        svld = '0;
        ARESETN = 1'b1;
        exp_fc = 0;
        exp_terr = 1'b0;
        rr_m = N - 1;
        do_frame(4'b1111, 0, 0, 1, 0, "post reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
